m68k_bus_arbiter: RTL and testbench
===================================

M68K_BUS_ARBITER -- requirements
Module: m68k_bus_arbiter

Interface
REQ-001 The parameter HOLD_MAX SHALL default to 255 and SHALL set the maximum number of clk16 cycles a requester may own the bus.
REQ-002 The parameter CNT_W SHALL default to 8 and SHALL set the width of the hold counter, which SHALL be at least clog2(HOLD_MAX+1).
REQ-003 Ports SHALL be as follows; one clock, asynchronous active-high reset:
- clk16  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- br_n  out  1  bus request to the 68000.
- bg_n  in  1  bus grant from the 68000.
- bgack_n  out  1  bus grant acknowledge to the 68000.
- as_n  in  1  68000 address strobe.
- dtack_n  in  1  bus DTACK.
- req  in  2  requester bus requests; req[0] is the DMA engine, req[1] is the debug port.
- gnt  out  2  one-hot bus ownership.
- timeout  out  1  one-cycle pulse when an owner is evicted.

Function
REQ-004 bg_n, as_n and dtack_n SHALL each pass through a 2-flop synchronizer on clk16 that resets to 1, and all decisions SHALL use the synchronized values.
REQ-005 The FSM SHALL have exactly five states: IDLE, REQ, WAITBUS, OWN and RELEASE.
REQ-006 IDLE: br_n=1, bgack_n=1, gnt=0; if any req bit is 1, the arbiter SHALL latch the winner into sel and go to REQ on the next edge.
REQ-007 Winner selection SHALL be round-robin: when both req bits are 1, the requester not equal to last SHALL win; a single active request SHALL win regardless of last.
REQ-008 REQ: br_n=0; when synchronized bg_n==0 the FSM SHALL go to WAITBUS.
REQ-009 REQ and WAITBUS: if req[sel] drops before OWN, the FSM SHALL return to IDLE, br_n SHALL return to 1 and last SHALL not change.
REQ-010 WAITBUS: br_n=0; when synchronized as_n==1 and dtack_n==1 in the same cycle, the FSM SHALL go to OWN.
REQ-011 On entry to OWN the arbiter SHALL drive bgack_n=0 and br_n=1, set gnt[sel]=1, load the hold counter with 0, and update last=sel.
REQ-012 OWN: the hold counter SHALL increment once per cycle and saturate at HOLD_MAX.
REQ-013 OWN: if req[sel]==0, the FSM SHALL go to RELEASE.
REQ-014 OWN: if the counter equals HOLD_MAX while req[sel]==1, the FSM SHALL go to RELEASE and pulse timeout for exactly one cycle.
REQ-015 RELEASE SHALL last one cycle with gnt=0 and bgack_n=1, then the FSM SHALL go to IDLE.
REQ-016 Requests SHALL not be re-evaluated in RELEASE, so there is a minimum 1-cycle gap between owners.
REQ-017 gnt SHALL be 1 only in OWN, SHALL be one-hot or zero, and SHALL equal 0 whenever bgack_n==1.
REQ-018 A change in the other req bit during OWN SHALL have no effect on the current owner.
REQ-019 All outputs SHALL be registered, with no combinational path from any input to any output.

Reset
REQ-020 While reset==1, the arbiter SHALL set state=IDLE, br_n=1, bgack_n=1, gnt=0, timeout=0, last=1 (so req[0] wins the first tie), the hold counter to 0 and all synchronizer flops to 1.
REQ-021 Asserting reset in any state SHALL release the bus immediately, with bgack_n and br_n going to 1 asynchronously.

Verification
REQ-022 Single request: req=01, bg_n low 3 cycles after br_n falls, as_n=dtack_n=1 -> br_n=0 until OWN; bgack_n=0, br_n=1, gnt=01 no earlier than 2 sync cycles after bg_n; req=00 -> gnt=00, bgack_n=1 one cycle later, then IDLE.
REQ-023 Tie and fairness: req=11 held continuously -> grants alternate 01, 10, 01, with exactly one all-zero gnt cycle between owners.
REQ-024 Bus busy: bg_n=0 while as_n=0 for 10 cycles -> remains in WAITBUS with bgack_n=1; as_n and dtack_n both high -> OWN within 3 cycles (2 sync + 1).
REQ-025 Timeout with HOLD_MAX=15: req=10 held forever -> gnt=10 for exactly 16 cycles, one timeout pulse, one gap cycle, then re-arbitration grants req[1] again.
REQ-026 Abort: req=01 dropped while in REQ -> br_n returns to 1, no gnt ever asserted, last unchanged.
REQ-027 Reset in OWN: reset pulsed mid-ownership -> gnt=00, bgack_n=1, br_n=1 asynchronously; after reset the next tie goes to req[0].

Source files
------------

// File: rtl/m68k_bus_arbiter.sv
// Arbitrates the 68000 bus between a DMA engine (req[0]) and a debug port (req[1]) using
// the BR/BG/BGACK handshake, with round-robin tie breaking and a bounded ownership time.
module m68k_bus_arbiter #(
  parameter int HOLD_MAX = 255,
  parameter int CNT_W    = 8
) (
  input  logic       clk16,
  input  logic       reset,
  output logic       br_n,
  input  logic       bg_n,
  output logic       bgack_n,
  input  logic       as_n,
  input  logic       dtack_n,
  input  logic [1:0] req,
  output logic [1:0] gnt,
  output logic       timeout
);

  typedef enum logic [2:0] {IDLE, REQ, WAITBUS, OWN, RELEASE} state_t;

  localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(HOLD_MAX);

  state_t           state;
  logic [1:0]       bg_sync;
  logic [1:0]       as_sync;
  logic [1:0]       dtack_sync;
  logic             sel;
  logic             last;
  logic             win;
  logic [CNT_W-1:0] hold_cnt;

  // CPU-side strobes are asynchronous to clk16; idle level is 1.
  always_ff @(posedge clk16 or posedge reset) begin
    if (reset) begin
      bg_sync    <= 2'b11;
      as_sync    <= 2'b11;
      dtack_sync <= 2'b11;
    end else begin
      bg_sync    <= {bg_sync[0], bg_n};
      as_sync    <= {as_sync[0], as_n};
      dtack_sync <= {dtack_sync[0], dtack_n};
    end
  end

  // On a tie the requester that did not own the bus last wins.
  always_comb begin
    win = (req == 2'b11) ? ~last : req[1];
  end

  always_ff @(posedge clk16 or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      br_n     <= 1'b1;
      bgack_n  <= 1'b1;
      gnt      <= 2'b00;
      timeout  <= 1'b0;
      last     <= 1'b1;
      sel      <= 1'b0;
      hold_cnt <= '0;
    end else begin
      timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (|req) begin
            sel   <= win;
            br_n  <= 1'b0;
            state <= REQ;
          end
        end
        REQ: begin
          if (!req[sel]) begin
            br_n  <= 1'b1;
            state <= IDLE;
          end else if (!bg_sync[1]) begin
            state <= WAITBUS;
          end
        end
        WAITBUS: begin
          if (!req[sel]) begin
            br_n  <= 1'b1;
            state <= IDLE;
          end else if (as_sync[1] && dtack_sync[1]) begin
            br_n     <= 1'b1;
            bgack_n  <= 1'b0;
            gnt      <= sel ? 2'b10 : 2'b01;
            hold_cnt <= '0;
            last     <= sel;
            state    <= OWN;
          end
        end
        OWN: begin
          if (hold_cnt != HOLD_LIM) hold_cnt <= hold_cnt + 1'b1;
          // A voluntary release takes precedence over eviction in the same cycle.
          if (!req[sel] || (hold_cnt == HOLD_LIM)) begin
            gnt     <= 2'b00;
            bgack_n <= 1'b1;
            timeout <= req[sel];
            state   <= RELEASE;
          end
        end
        RELEASE: begin
          state <= IDLE;
        end
        default: begin
          br_n    <= 1'b1;
          bgack_n <= 1'b1;
          gnt     <= 2'b00;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_m68k_bus_arbiter.sv
// Randomized scoreboard bench for m68k_bus_arbiter: the stimulus side predicts each bus
// tenure (owner, length, eviction) and a monitor checks every tenure the DUT produces.
module tb_m68k_bus_arbiter;

  localparam int HM = 15;

  logic       clk16 = 1'b0;
  logic       reset;
  logic       br_n;
  logic       bg_n;
  logic       bgack_n;
  logic       as_n;
  logic       dtack_n;
  logic [1:0] req;
  logic [1:0] gnt;
  logic       timeout;

  m68k_bus_arbiter #(.HOLD_MAX(HM), .CNT_W(4)) dut (
    .clk16(clk16), .reset(reset), .br_n(br_n), .bg_n(bg_n), .bgack_n(bgack_n),
    .as_n(as_n), .dtack_n(dtack_n), .req(req), .gnt(gnt), .timeout(timeout)
  );

  always #5 clk16 = ~clk16;

  typedef struct {
    logic owner;
    int   dur;
    logic to;
    logic cut;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cpu_mode = 0;   // 0 random bus traffic, 1 bus held busy, 2 bus idle
  logic model_last = 1'b1;

  task automatic chk(input string name, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s: actual %0d required %0d", name, act, exp_v);
    end
  endtask

  task automatic abort_run(input string name);
    errors++;
    $display("FAIL %s: wait bound expired", name);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  endtask

  // Reference rule: a tie goes to whoever did not own last, otherwise the sole requester.
  function automatic logic pick(input logic [1:0] p);
    logic o;
    o = (p == 2'b11) ? ~model_last : p[1];
    model_last = o;
    return o;
  endfunction

  function automatic void push(input logic o, input int d, input logic t, input logic c);
    exp_t e;
    e.owner = o; e.dur = d; e.to = t; e.cut = c;
    q.push_back(e);
  endfunction

  // 68000 model: grants some cycles after BR, and generates its own bus cycles when not off-bus.
  initial begin
    int bg_dly;
    bg_n = 1'b1; as_n = 1'b1; dtack_n = 1'b1; bg_dly = 2;
    forever begin
      @(posedge clk16); #2;
      if (br_n == 1'b0) begin
        if (bg_dly > 0) bg_dly--;
        else bg_n = 1'b0;
      end else begin
        bg_n   = 1'b1;
        bg_dly = $urandom_range(0, 4);
      end
      if (cpu_mode == 1) begin
        as_n = 1'b0; dtack_n = 1'b1;
      end else if (cpu_mode == 2 || bgack_n == 1'b0) begin
        as_n = 1'b1; dtack_n = 1'b1;
      end else begin
        as_n    = ($urandom_range(0, 3) != 0);
        dtack_n = ($urandom_range(0, 3) != 0);
      end
    end
  end

  // Monitor: tracks each tenure from gnt and checks it against the scoreboard.
  logic [1:0] cur = 2'b00;
  int         dur = 0;
  bit         in_ten = 1'b0;

  always @(negedge clk16) begin
    bit   ended;
    exp_t e;
    ended = 1'b0;
    if (reset) begin
      if (in_ten) begin
        in_ten = 1'b0;
        if (q.size() == 0) chk("reset_cut_unexpected", 1, 0);
        else begin
          e = q.pop_front();
          chk("reset_cut_expected", e.cut, 1);
        end
      end
    end else begin
      checks++;
      if (gnt == 2'b11 || ((gnt != 2'b00) != (bgack_n == 1'b0))) begin
        errors++;
        $display("FAIL gnt_bgack_invariant: gnt=%b bgack_n=%b", gnt, bgack_n);
      end
      if (in_ten) begin
        if (gnt == cur) dur++;
        else begin
          ended  = 1'b1;
          in_ten = 1'b0;
          chk("handover_gap", gnt, 0);
          if (q.size() == 0) chk("tenure_unexpected", 1, 0);
          else begin
            e = q.pop_front();
            chk("tenure_owner", cur, e.owner ? 2 : 1);
            chk("tenure_len", dur, e.dur);
            chk("tenure_timeout", timeout, e.to);
            chk("tenure_not_cut", e.cut, 0);
          end
        end
      end else if (gnt != 2'b00) begin
        if (q.size() == 0) chk("grant_unexpected", gnt, 0);
        cur    = gnt;
        dur    = 1;
        in_ten = 1'b1;
      end
      if (timeout && !ended) chk("timeout_stray", timeout, 0);
    end
  end

  task automatic wait_grant();
    for (int i = 0; i < 300; i++) begin
      @(posedge clk16); #1;
      if (gnt != 2'b00) return;
    end
    abort_run("grant_wait");
  endtask

  task automatic wait_gnt_low(input int n);
    for (int i = 0; i < n; i++) begin
      if (gnt == 2'b00) return;
      @(posedge clk16); #1;
    end
    abort_run("release_wait");
  endtask

  task automatic hold_drop(input int l, input logic o, input bit tog);
    for (int i = 0; i < l; i++) begin
      @(posedge clk16); #1;
      if (gnt == 2'b00) break;
      if (tog) req[~o] = 1'($urandom_range(0, 1));
    end
    req = 2'b00;
    wait_gnt_low(5);
    repeat (3) begin @(posedge clk16); #1; end
  endtask

  // nto evictions with the request held, then a tenure of l further cycles before dropping.
  task automatic run(input logic [1:0] p, input int nto, input int l, input bit tog);
    logic o;
    o = 1'b0;
    for (int k = 0; k < nto; k++) begin
      o = pick(p);
      push(o, HM + 1, 1'b1, 1'b0);
    end
    o = pick(p);
    push(o, (l + 1 < HM + 1) ? l + 1 : HM + 1, (l >= HM + 1), 1'b0);
    req = p;
    for (int k = 0; k < nto; k++) begin
      wait_grant();
      wait_gnt_low(HM + 5);
    end
    wait_grant();
    hold_drop(l, o, tog);
  endtask

  task automatic abort_req(input logic [1:0] p);
    int i;
    req = p;
    for (i = 0; i < 20; i++) begin
      @(posedge clk16); #1;
      if (br_n == 1'b0) break;
    end
    if (i == 20) abort_run("abort_br_wait");
    req = 2'b00;
    repeat (2) begin @(posedge clk16); #1; end
    chk("abort_br_n", br_n, 1);
    repeat (2) begin @(posedge clk16); #1; end
  endtask

  task automatic bus_busy();
    logic o;
    int   i;
    int   bad;
    cpu_mode = 1;
    o = pick(2'b01);
    push(o, 5, 1'b0, 1'b0);
    req = 2'b01;
    for (i = 0; i < 40; i++) begin
      @(posedge clk16); #1;
      if (br_n == 1'b0 && bg_n == 1'b0) break;
    end
    if (i == 40) abort_run("busy_bg_wait");
    bad = 0;
    repeat (10) begin
      @(posedge clk16); #1;
      if (bgack_n != 1'b1) bad = 1;
    end
    chk("busy_stays_waitbus", bad, 0);
    cpu_mode = 2;
    for (i = 1; i <= 6; i++) begin
      @(posedge clk16); #1;
      if (bgack_n == 1'b0) break;
    end
    if (i > 6) abort_run("busy_release_wait");
    chk("busy_own_within_3", (i <= 3), 1);
    hold_drop(4, o, 1'b0);
    cpu_mode = 0;
  endtask

  task automatic reset_in_own();
    logic o;
    o = pick(2'b01);
    push(o, 0, 1'b0, 1'b1);
    req = 2'b01;
    wait_grant();
    repeat (5) begin @(posedge clk16); #1; end
    #2 reset = 1'b1;
    #1;
    chk("rst_async_gnt", gnt, 0);
    chk("rst_async_bgack_n", bgack_n, 1);
    chk("rst_async_br_n", br_n, 1);
    chk("rst_async_timeout", timeout, 0);
    model_last = 1'b1;
    req = 2'b00;
    repeat (2) @(posedge clk16);
    #1 reset = 1'b0;
    repeat (2) begin @(posedge clk16); #1; end
  endtask

  initial begin
    reset = 1'b1;
    req   = 2'b00;
    repeat (3) @(posedge clk16);
    #1;
    chk("reset_br_n", br_n, 1);
    chk("reset_bgack_n", bgack_n, 1);
    chk("reset_gnt", gnt, 0);
    chk("reset_timeout", timeout, 0);
    reset = 1'b0;
    repeat (2) begin @(posedge clk16); #1; end

    run(2'b01, 0, 5, 1'b0);     // single DMA request
    run(2'b11, 2, 6, 1'b0);     // continuous tie: alternating owners
    run(2'b10, 1, 3, 1'b0);     // eviction then re-grant to the debug port
    bus_busy();
    abort_req(2'b01);
    run(2'b11, 0, 2, 1'b0);     // tie after abort follows the unchanged history
    reset_in_own();
    run(2'b11, 0, 2, 1'b0);     // first tie after reset goes to req[0]

    for (int n = 0; n < 40; n++) begin
      logic [1:0] p;
      p = 2'($urandom_range(1, 3));
      if ($urandom_range(0, 5) == 0) abort_req((p == 2'b11) ? 2'b10 : p);
      else run(p, 0, $urandom_range(0, 20), 1'($urandom_range(0, 1)));
    end

    repeat (10) @(posedge clk16);
    #1;
    chk("scoreboard_drained", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
